integrator_dump_n: RTL and testbench
====================================

Name: integrator_dump_n

Overview:
Parametrised multi-channel signed integrator. It is the successor to the single-channel 10-bit running integrator. It adds:
- N parallel lanes with configurable input and accumulator widths.
- An integrate-and-dump mode with a programmable window length.
- Optional saturation, with a sticky overflow flag per lane.
- A valid/clear sample interface.

It sits between the sample source and the downstream decimating filter stage.

Parameters:
- CHANNELS, 4, number of independent lanes
- IN_W, 10, signed input sample width per lane
- ACC_W, 16, signed accumulator/output width per lane (ACC_W >= IN_W)
- DUMP_LEN, 8, samples per dump window (>= 1)
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
- system1000  in  1  clock, rising edge
- system1000_rst  in  1  asynchronous reset, active-high
- in_valid  in  1  sample strobe, common to all lanes
- in_data  in  CHANNELS*IN_W  signed samples; lane k at [k*IN_W +: IN_W]
- clear  in  1  synchronous flush of all lanes
- mode_dump  in  1  1 = integrate-and-dump, 0 = running integrator
- out_valid  out  1  result strobe
- out_data  out  CHANNELS*ACC_W  signed results; lane k at [k*ACC_W +: ACC_W]
- overflow  out  CHANNELS  sticky per-lane overflow flag

Behaviour:
- Reset (async assert, sync release): all accumulators, window counter, out_data, out_valid, overflow and the registered mode copy are 0.
- Arithmetic: each sample is sign-extended to ACC_W+1 bits. sum = acc + sample is computed at ACC_W+1 bits.
  - Overflow occurs when sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=1: clamp to the nearest bound. SATURATE=0: keep the low ACC_W bits.
  - Either way, overflow[k] is set and stays set until clear or reset.
- Running mode (mode_dump=0): on an edge with in_valid=1, acc <= sum and out_data <= sum. out_valid=1 for exactly that following cycle (latency 1). With in_valid=0, acc and out_data hold and out_valid=0.
- Dump mode (mode_dump=1):
  - cnt counts accepted samples, 0..DUMP_LEN-1.
  - On an accepted sample with cnt<DUMP_LEN-1: acc <= sum, cnt++, out_valid=0.
  - On an accepted sample with cnt==DUMP_LEN-1: out_data <= sum, out_valid pulses 1 cycle, acc <= 0, cnt <= 0.
  - out_data holds between dumps.
  - DUMP_LEN=1 degenerates to a registered pass-through of the sign-extended sample.
- Priority per edge: reset > clear > mode change > sample.
- clear=1: acc, cnt and overflow go to 0. out_valid=0. out_data holds. A simultaneous in_valid sample is discarded.
- Mode change: mode_dump is registered each cycle. A cycle where mode_dump differs from the registered copy acts as clear, and any sample in that cycle is discarded.
- in_valid gaps never advance cnt. A window spans any number of cycles.
- Saturated accumulators keep integrating from the clamped value; a later opposite-sign sample moves off the rail.
- Overflow in dump mode affects only the current window's value; the flag stays sticky.
- All lanes share cnt and out_valid; lanes never interact arithmetically.

Decomposition:
- Shared package integrator_pkg:
  - ACC_MAX/ACC_MIN constant functions of ACC_W.
  - Function sat_add(acc, sample, saturate), returning the result and an ovf bit.
  - Mode encoding constants MODE_RUN=0, MODE_DUMP=1.
- Sub-module integrator_lane: one accumulator plus overflow flag, driven by shared accept/dump/flush strobes.
- Top level: window counter, mode register, clear/priority logic, and a generate loop over CHANNELS lanes.

Test Plan (CHANNELS=4, IN_W=10, ACC_W=16, DUMP_LEN=8):
1. Assert system1000_rst mid-window between clock edges. Required: out_data=0, out_valid=0 and overflow=0 immediately. After release, a full 8-sample window is needed before the next dump.
2. Running mode, lane0 samples 5, 5, -3 on consecutive cycles. Required: out_data lane0 = 5, 10, 7, each one cycle later with out_valid=1. A gap cycle gives out_valid=0 and lane0 holds 7.
3. Dump mode, lane1 = 100 for 8 valid samples with two idle cycles inserted. Required: a single out_valid pulse with lane1 = 800 after the 8th sample. The next window of -1 x8 dumps -8.
4. Running mode, lane2 = 511 every cycle.
   - SATURATE=1: output reaches 32767 on the 65th sample and holds; overflow[2]=1, other flags 0.
   - SATURATE=0: 65th output is -32321; overflow[2]=1.
5. clear and in_valid in the same cycle after acc=300 with overflow set. Required: no out_valid, sample dropped, acc=0, overflow=0. The next sample of 4 gives output 4.
6. Toggle mode_dump 0->1 after 3 accepted samples, with a sample present in the toggle cycle. Required: sample discarded, cnt=0. The dump occurs after exactly 8 further samples.

Source files
------------

// File: rtl/integrator_pkg.sv
// Shared types, bounds and saturating add for the multi-channel integrator.
package integrator_pkg;

    // Working width for the generic arithmetic helpers; lanes truncate to ACC_W.
    localparam int unsigned MAX_W = 64;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        wide_t result;
        logic  ovf;
    } sat_res_t;

    // Largest value representable in an acc_w-bit signed accumulator.
    function automatic wide_t acc_max(input int unsigned acc_w);
        wide_t one;
        one = wide_t'(1);
        return (one <<< (acc_w - 1)) - one;
    endfunction

    // Smallest value representable in an acc_w-bit signed accumulator.
    function automatic wide_t acc_min(input int unsigned acc_w);
        wide_t one;
        one = wide_t'(1);
        return -(one <<< (acc_w - 1));
    endfunction

    // Add a sign-extended sample to the accumulator; clamp or wrap to acc_w bits.
    function automatic sat_res_t sat_add(input wide_t       acc,
                                         input wide_t       sample,
                                         input logic        saturate,
                                         input int unsigned acc_w);
        sat_res_t r;
        wide_t    sum;
        wide_t    hi;
        wide_t    lo;
        hi    = acc_max(acc_w);
        lo    = acc_min(acc_w);
        sum   = acc + sample;
        r.ovf = (sum > hi) || (sum < lo);
        if (saturate && (sum > hi)) begin
            r.result = hi;
        end else if (saturate && (sum < lo)) begin
            r.result = lo;
        end else begin
            // Keep the low acc_w bits, re-sign-extended to the working width.
            r.result = (sum <<< (MAX_W - acc_w)) >>> (MAX_W - acc_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/integrator_lane.sv
// One integrator lane: accumulator, output register and sticky overflow flag.
module integrator_lane
    import integrator_pkg::*;
#(
    parameter int unsigned IN_W     = 10,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned SATURATE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    accept_i,
    input  logic                    emit_i,
    input  logic                    dump_i,
    input  logic                    flush_i,
    input  logic signed [IN_W-1:0]  sample_i,
    output logic signed [ACC_W-1:0] out_o,
    output logic                    ovf_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] out_q;
    logic signed [ACC_W-1:0] out_d;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf_q;
    logic                    ovf_d;
    sat_res_t                res;

    // Next-state: flush wins, otherwise an accepted sample updates the lane.
    always_comb begin
        res   = sat_add(wide_t'(acc_q), wide_t'(sample_i), SATURATE != 0, ACC_W);
        sum   = ACC_W'(res.result);
        acc_d = acc_q;
        out_d = out_q;
        ovf_d = ovf_q;
        if (flush_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (accept_i) begin
            ovf_d = ovf_q | res.ovf;
            // At a window end the accumulator restarts from zero.
            acc_d = dump_i ? '0 : sum;
            if (emit_i) begin
                out_d = sum;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_o = out_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/integrator_dump_n.sv
// Multi-channel signed integrator with running and integrate-and-dump modes.
module integrator_dump_n
    import integrator_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IN_W     = 10,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned DUMP_LEN = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic                      system1000,
    input  logic                      system1000_rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    input  logic                      clear,
    input  logic                      mode_dump,
    output logic                      out_valid,
    output logic [CHANNELS*ACC_W-1:0] out_data,
    output logic [CHANNELS-1:0]       overflow
);

    localparam int unsigned      CNT_W    = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN - 1);

    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_valid_q;
    logic             flush;
    logic             accept;
    logic             win_end;
    logic             emit;
    logic             dump;

    // Shared strobes: clear and a mode change both flush and drop the sample.
    always_comb begin
        flush   = clear | (mode_dump != mode_q);
        accept  = in_valid & ~flush;
        win_end = (mode_q == MODE_DUMP) && (cnt_q == CNT_LAST);
        emit    = accept & ((mode_q == MODE_RUN) | win_end);
        dump    = accept & win_end;
    end

    // Window counter advances only on accepted samples in dump mode.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept && (mode_q == MODE_DUMP)) begin
            cnt_d = win_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Mode copy, window counter and result strobe.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            mode_q      <= MODE_RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_dump;
            cnt_q       <= cnt_d;
            out_valid_q <= emit;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        integrator_lane #(
            .IN_W     (IN_W),
            .ACC_W    (ACC_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk_i    (system1000),
            .rst_i    (system1000_rst),
            .accept_i (accept),
            .emit_i   (emit),
            .dump_i   (dump),
            .flush_i  (flush),
            .sample_i (in_data[k*IN_W +: IN_W]),
            .out_o    (out_data[k*ACC_W +: ACC_W]),
            .ovf_o    (overflow[k])
        );
    end

endmodule

// File: tb/tb_integrator_dump_n.sv
// Scoreboard bench for integrator_dump_n: saturating and wrapping instances side by side.
module tb_integrator_dump_n;

    localparam longint ACC_MAX = 32767;
    localparam longint ACC_MIN = -32768;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [39:0] in_data;
    logic        clear;
    logic        mode_dump;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  overflow;
    logic        out_valid_w;
    logic [63:0] out_data_w;
    logic [3:0]  overflow_w;

    integrator_dump_n #(
        .CHANNELS (4), .IN_W (10), .ACC_W (16), .DUMP_LEN (8), .SATURATE (1)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .clear          (clear),
        .mode_dump      (mode_dump),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .overflow       (overflow)
    );

    integrator_dump_n #(
        .CHANNELS (4), .IN_W (10), .ACC_W (16), .DUMP_LEN (8), .SATURATE (0)
    ) dut_wrap (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .clear          (clear),
        .mode_dump      (mode_dump),
        .out_valid      (out_valid_w),
        .out_data       (out_data_w),
        .overflow       (overflow_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d_s;
        logic [63:0] d_w;
        logic [3:0]  o_s;
        logic [3:0]  o_w;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    int     pulses;

    // Reference model state (saturating and wrapping variants).
    longint m_acc_s[4];
    longint m_acc_w[4];
    logic [3:0] m_ovf_s;
    logic [3:0] m_ovf_w;
    int     m_cnt;
    logic   m_mode;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [39:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    endfunction

    function automatic longint lane(input logic [63:0] bus, input int k);
        logic signed [15:0] t;
        t = bus[k*16 +: 16];
        return longint'(t);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc_s[k] = 0;
            m_acc_w[k] = 0;
        end
        m_ovf_s = '0;
        m_ovf_w = '0;
        m_cnt   = 0;
        m_mode  = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic v, input logic [39:0] d, input logic clr,
                              input logic md, output logic emit, output exp_t e);
        logic        chg;
        logic        last;
        logic [9:0]  s10;
        logic [15:0] low;
        longint      samp;
        longint      sum;
        longint      res_s;
        longint      res_w;
        chg    = (md != m_mode);
        m_mode = md;
        emit   = 1'b0;
        e      = '0;
        if (clr || chg) begin
            for (int k = 0; k < 4; k++) begin
                m_acc_s[k] = 0;
                m_acc_w[k] = 0;
            end
            m_ovf_s = '0;
            m_ovf_w = '0;
            m_cnt   = 0;
        end else if (v) begin
            last = md && (m_cnt == 7);
            for (int k = 0; k < 4; k++) begin
                s10  = d[k*10 +: 10];
                samp = longint'($signed(s10));
                sum  = m_acc_s[k] + samp;
                res_s = sum;
                if (sum > ACC_MAX) begin
                    res_s = ACC_MAX;
                    m_ovf_s[k] = 1'b1;
                end else if (sum < ACC_MIN) begin
                    res_s = ACC_MIN;
                    m_ovf_s[k] = 1'b1;
                end
                sum = m_acc_w[k] + samp;
                if (sum > ACC_MAX || sum < ACC_MIN) m_ovf_w[k] = 1'b1;
                low   = sum[15:0];
                res_w = longint'($signed(low));
                e.d_s[k*16 +: 16] = res_s[15:0];
                e.d_w[k*16 +: 16] = res_w[15:0];
                m_acc_s[k] = (md && last) ? 0 : res_s;
                m_acc_w[k] = (md && last) ? 0 : res_w;
            end
            emit = !md || last;
            if (md) m_cnt = last ? 0 : m_cnt + 1;
        end
        e.o_s = m_ovf_s;
        e.o_w = m_ovf_w;
    endtask

    // Drive one cycle, push expectation, compare any result one cycle later.
    task automatic step(input logic v, input logic [39:0] d, input logic clr, input logic md);
        exp_t e;
        logic emit;
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        mode_dump = md;
        model_step(v, d, clr, md, emit, e);
        if (emit) sb.push_back(e);
        @(posedge clk);
        #1;
        check_eq("out_valid", longint'(out_valid), longint'(emit));
        check_eq("out_valid_wrap", longint'(out_valid_w), longint'(emit));
        pulses += int'(out_valid);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", longint'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check_eq("sb_data_sat", longint'(out_data), longint'(e.d_s));
                check_eq("sb_data_wrap", longint'(out_data_w), longint'(e.d_w));
                check_eq("sb_ovf_sat", longint'(overflow), longint'(e.o_s));
                check_eq("sb_ovf_wrap", longint'(overflow_w), longint'(e.o_w));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; mode_dump = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_out_data", longint'(out_data), 0);
        check_eq("rst_overflow", longint'(overflow), 0);

        // Running mode: 5, 5, -3 then a gap.
        step(1, pk(5, 0, 0, 0), 0, 0);
        check_eq("run_5", lane(out_data, 0), 5);
        step(1, pk(5, 0, 0, 0), 0, 0);
        check_eq("run_10", lane(out_data, 0), 10);
        step(1, pk(-3, 0, 0, 0), 0, 0);
        check_eq("run_7", lane(out_data, 0), 7);
        step(0, pk(9, 9, 9, 9), 0, 0);
        check_eq("run_gap_hold", lane(out_data, 0), 7);

        // Dump mode: lane1 = 100 x8 with two idle cycles, then -1 x8.
        step(0, '0, 0, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 6) step(0, pk(0, 7, 0, 0), 0, 1);
            else step(1, pk(0, 100, 0, 0), 0, 1);
        end
        check_eq("dump_800", lane(out_data, 1), 800);
        check_eq("dump_pulses", pulses, 1);
        for (int i = 0; i < 8; i++) step(1, pk(0, -1, 0, 0), 0, 1);
        check_eq("dump_neg8", lane(out_data, 1), -8);

        // Running mode saturation / wrap on lane2.
        step(0, '0, 0, 0);
        for (int i = 1; i <= 65; i++) begin
            step(1, pk(0, 0, 511, 0), 0, 0);
            if (i == 64) begin
                check_eq("sat_64", lane(out_data, 2), 32704);
                check_eq("sat_64_ovf", longint'(overflow), 0);
            end
        end
        check_eq("sat_65", lane(out_data, 2), 32767);
        check_eq("wrap_65", lane(out_data_w, 2), -32321);
        check_eq("sat_65_ovf", longint'(overflow), 4);
        check_eq("wrap_65_ovf", longint'(overflow_w), 4);
        step(1, pk(0, 0, 511, 0), 0, 0);
        check_eq("sat_hold", lane(out_data, 2), 32767);

        // Walk lane2 down to 300, then clear together with a sample.
        for (int i = 0; i < 63; i++) step(1, pk(0, 0, -511, 0), 0, 0);
        step(1, pk(0, 0, -274, 0), 0, 0);
        check_eq("off_rail_300", lane(out_data, 2), 300);
        check_eq("off_rail_ovf", longint'(overflow), 4);
        step(1, pk(0, 0, 50, 0), 1, 0);
        check_eq("clr_ovf", longint'(overflow), 0);
        check_eq("clr_hold", lane(out_data, 2), 300);
        step(1, pk(0, 0, 4, 0), 0, 0);
        check_eq("clr_then_4", lane(out_data, 2), 4);
        check_eq("clr_then_4_wrap", lane(out_data_w, 2), 4);

        // Mode toggle with a sample present after three accepted samples.
        step(1, pk(0, 0, 0, 1), 0, 0);
        step(1, pk(0, 0, 0, 2), 0, 0);
        step(1, pk(0, 0, 0, 3), 0, 0);
        check_eq("toggle_pre", lane(out_data, 3), 6);
        pulses = 0;
        step(1, pk(0, 0, 0, 100), 0, 1);
        for (int i = 0; i < 8; i++) step(1, pk(0, 0, 0, 1), 0, 1);
        check_eq("toggle_dump", lane(out_data, 3), 8);
        check_eq("toggle_pulses", pulses, 1);

        // Asynchronous reset in the middle of a dump window.
        for (int i = 0; i < 3; i++) step(1, pk(2, 0, 0, 0), 0, 1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", longint'(out_valid), 0);
        check_eq("arst_out_data", longint'(out_data), 0);
        check_eq("arst_out_data_wrap", longint'(out_data_w), 0);
        check_eq("arst_overflow", longint'(overflow_w), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        step(0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, pk(3, 0, 0, 0), 0, 1);
        check_eq("arst_full_window", lane(out_data, 0), 24);
        check_eq("arst_pulses", pulses, 1);
        check_eq("sb_drained", longint'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
